// File: rtl/mailbox_receive_queue_pkg.sv
// xctcmsg_defs: shared mailbox message, request and writeback types.
package xctcmsg_defs;
    localparam int MAILBOX_DEPTH = 4;
    typedef enum logic [1:0] {RECV, PEEK_SENDER, AVAILABLE} mailbox_op_e;
    typedef enum logic {IDLE, RESPOND} mailbox_state_e;
    typedef struct packed {
        logic [3:0]  sender;
        logic [63:0] payload;
    } mailbox_message_t;
    typedef struct packed {
        mailbox_op_e op;
        logic [4:0]  rd;
    } mailbox_request_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] value;
    } writeback_arbiter_data_t;
endpackage

// File: rtl/mailbox_receive_queue_if.sv
// mailbox_receive_queue_if: network delivery, decode request and writeback handshakes.
interface mailbox_receive_queue_if;
    import xctcmsg_defs::*;
    logic                    interface_mailbox_valid;
    logic                    mailbox_interface_ready;
    mailbox_message_t        interface_mailbox_data;
    logic                    decode_mailbox_valid;
    logic                    mailbox_decode_ready;
    mailbox_request_t        decode_mailbox_request;
    logic                    mailbox_writeback_arbiter_valid;
    logic                    writeback_arbiter_mailbox_acknowledge;
    writeback_arbiter_data_t mailbox_writeback_arbiter_data;
    modport master (
        output interface_mailbox_valid, interface_mailbox_data, decode_mailbox_valid,
               decode_mailbox_request, writeback_arbiter_mailbox_acknowledge,
        input  mailbox_interface_ready, mailbox_decode_ready,
               mailbox_writeback_arbiter_valid, mailbox_writeback_arbiter_data
    );
    modport slave (
        input  interface_mailbox_valid, interface_mailbox_data, decode_mailbox_valid,
               decode_mailbox_request, writeback_arbiter_mailbox_acknowledge,
        output mailbox_interface_ready, mailbox_decode_ready,
               mailbox_writeback_arbiter_valid, mailbox_writeback_arbiter_data
    );
endinterface

// File: rtl/mailbox_receive_queue_fifo.sv
// mailbox_fifo: message storage with wrapping pointers; push is refused while full.
module mailbox_fifo
    import xctcmsg_defs::*;
#(
    parameter int DEPTH = MAILBOX_DEPTH,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  mailbox_message_t push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output mailbox_message_t head
);
    mailbox_message_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    // Storage is deliberately unreset; it is only visible while count is nonzero.
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mailbox_receive_queue.sv
// mailbox_receive_queue: buffers incoming messages and answers RECV/PEEK_SENDER/AVAILABLE
// requests with a single held writeback result.
module mailbox_receive_queue
    import xctcmsg_defs::*;
#(
    parameter int DEPTH = MAILBOX_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    mailbox_receive_queue_if.slave mbx
);
    localparam int CW = $clog2(DEPTH + 1);
    mailbox_state_e          state_q, state_d;
    mailbox_op_e             op, op_q;
    writeback_arbiter_data_t wb_q;
    mailbox_message_t        head;
    logic [CW-1:0]           count;
    logic [63:0]             value;
    logic full, empty, op_ok, ready, accept, pop;
    mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mbx.interface_mailbox_valid),
        .push_data (mbx.interface_mailbox_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );
    assign mbx.mailbox_interface_ready         = !full;
    assign mbx.mailbox_decode_ready            = ready;
    assign mbx.mailbox_writeback_arbiter_valid = state_q == RESPOND;
    assign mbx.mailbox_writeback_arbiter_data  = wb_q;
    always_comb begin
        op      = mbx.decode_mailbox_request.op;
        op_ok   = op == AVAILABLE ? 1'b1 : (op == RECV || op == PEEK_SENDER) ? !empty : 1'b0;
        ready   = rst_n && state_q == IDLE && !flush && op_ok;
        accept  = mbx.decode_mailbox_valid && ready;
        value   = op == RECV ? head.payload : op == PEEK_SENDER ? 64'(head.sender) : 64'(count);
        // Acknowledge takes priority over flush, so a flushed-but-acked RECV still pops.
        pop     = state_q == RESPOND && mbx.writeback_arbiter_mailbox_acknowledge && op_q == RECV;
        state_d = state_q == IDLE ? (accept ? RESPOND : IDLE)
                : (mbx.writeback_arbiter_mailbox_acknowledge || flush) ? IDLE : RESPOND;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= RECV;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= op;
                wb_q <= '{rd: mbx.decode_mailbox_request.rd, value: value};
            end
        end
    end
endmodule

// File: doc/mailbox_receive_queue.md
MAILBOX_RECEIVE_QUEUE -- requirements
Module: mailbox_receive_queue

Interface
REQ-001 SHALL have parameter DEPTH, default MAILBOX_DEPTH (4), meaning number of buffered incoming messages; power of two, >= 2.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port flush  in  1  pipeline flush; discards the pending response.
REQ-005 SHALL have port interface_mailbox_valid  in  1  network delivers a message.
REQ-006 SHALL have port mailbox_interface_ready  out  1  queue can accept a message.
REQ-007 SHALL have port interface_mailbox_data  in  mailbox_message_t  {sender[3:0], payload[63:0]}.
REQ-008 SHALL have port decode_mailbox_valid  in  1  core issues a mailbox request.
REQ-009 SHALL have port mailbox_decode_ready  out  1  request accepted this cycle.
REQ-010 SHALL have port decode_mailbox_request  in  mailbox_request_t  {op: mailbox_op_e, rd[4:0]}.
REQ-011 SHALL have port mailbox_writeback_arbiter_valid  out  1  result pending for writeback.
REQ-012 SHALL have port writeback_arbiter_mailbox_acknowledge  in  1  arbiter consumed the result.
REQ-013 SHALL have port mailbox_writeback_arbiter_data  out  writeback_arbiter_data_t  {rd[4:0], value[63:0]}.

Function
REQ-014 SHALL implement a FIFO of DEPTH mailbox_message_t entries with read/write pointers and a count of width $clog2(DEPTH+1).
REQ-015 SHALL drive mailbox_interface_ready = (count != DEPTH); push on valid && ready; no full-bypass (pop and push in the same cycle while full: push is not accepted).
REQ-016 SHALL use a two-state FSM: IDLE (no result held), RESPOND (result held, valid=1).
REQ-017 SHALL drive mailbox_decode_ready in IDLE only, when flush=0, and: op RECV or PEEK_SENDER -> count != 0 (registered count; a same-cycle push does not count); op AVAILABLE -> always.
REQ-018 SHALL, on accept (IDLE, valid && ready), register rd and value, and enter RESPOND the next cycle (latency 1).
REQ-019 SHALL compute value as: RECV -> head.payload; PEEK_SENDER -> head.sender zero-extended to 64 b; AVAILABLE -> count zero-extended to 64 b.
REQ-020 SHALL drive mailbox_writeback_arbiter_valid = 1 exactly in RESPOND; data held stable while valid and unacknowledged.
REQ-021 SHALL, on acknowledge in RESPOND, pop the head if the held op is RECV, and return to IDLE next cycle; PEEK_SENDER and AVAILABLE never pop.
REQ-022 SHALL, on flush in RESPOND without acknowledge, return to IDLE with no pop; flush with acknowledge in the same cycle: acknowledge wins and the pop occurs.
REQ-023 SHALL NOT clear FIFO contents or pointers on flush; delivered messages are architectural state.
REQ-024 SHALL wrap pointers modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-025 SHALL sustain at most one request per two cycles; back-to-back: accept N, valid N+1, ack M, next accept M+1 earliest.

Reset
REQ-026 SHALL, on rst_n low (any time, mid-response included), force state IDLE, pointers 0, count 0, writeback valid 0, writeback data 0, mailbox_decode_ready 0; mailbox_interface_ready 1 once reset is released.
REQ-027 SHALL leave FIFO storage contents unreset (don't-care, never observable while count=0).

Structure
REQ-028 SHALL declare mailbox_message_t, mailbox_request_t, mailbox_op_e {RECV, PEEK_SENDER, AVAILABLE} and MAILBOX_DEPTH in package xctcmsg_defs; writeback_arbiter_data_t is reused from that package.
REQ-029 SHALL place storage and pointers in one sub-module mailbox_fifo (push/pop/full/empty/count/head); the FSM and result mux stay in mailbox_receive_queue.

Verification
REQ-030 Reset, then push {sender=3, payload=0xDEAD_BEEF}; RECV rd=7 -> valid next cycle, data {rd=7, value=0xDEAD_BEEF}; ack -> count 1->0.
REQ-031 Empty queue, RECV held valid 5 cycles -> decode_ready 0 throughout; push at cycle 5 -> accept at cycle 6, valid at cycle 7.
REQ-032 Push 4 messages (DEPTH=4) -> interface_ready 0; 5th held; RECV+ack pops head in the same cycle the 5th is offered -> 5th not taken that cycle, accepted the following cycle, FIFO order preserved.
REQ-033 count=2, PEEK_SENDER rd=1 -> value=sender zero-extended, count stays 2; AVAILABLE rd=2 -> value=2.
REQ-034 RECV accepted, flush in RESPOND with ack=0 -> valid drops next cycle, count unchanged; repeat RECV returns the same payload.
REQ-035 rst_n asserted while in RESPOND with count=3 -> valid 0, count 0, interface_ready 1 after release.
